// File: rtl/chase_sequencer.sv
// Chasing-LED sequencer: prescaled step timing, wrap/ping-pong position walk and lap counting.
// Define CHASE_TRAIL_EN to show a three-LED comet (pos plus the two previous positions) on led.
module chase_sequencer #(
   parameter int unsigned CLK_DIV_BASE = 4,
   parameter int unsigned N_LEDS       = 16,
   parameter int unsigned SPEED_W      = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stop,
   input  logic [SPEED_W-1:0]        speed,
   input  logic                      mode,
   output logic [N_LEDS-1:0]         led,
   output logic [$clog2(N_LEDS)-1:0] pos,
   output logic                      dir,
   output logic                      step,
   output logic [7:0]                laps
);

   localparam int unsigned POS_W = $clog2(N_LEDS);
   localparam int unsigned PRE_W = $clog2(CLK_DIV_BASE);
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LEDS - 1);
   localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_DIV_BASE - 1);

   typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

   state_e             state_q, state_d;
   logic [PRE_W-1:0]   presc_q, presc_d;
   logic [SPEED_W-1:0] tick_q, tick_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic               dir_q, dir_d;
   logic [7:0]         laps_q, laps_d;
   logic               step_q, step_d;
   logic               advance;

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      tick_d  = tick_q;
      speed_d = speed_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      laps_d  = laps_q;
      step_d  = 1'b0;
      advance = 1'b0;

      unique case (state_q)
         StIdle: begin
            speed_d = speed;
            state_d = stop ? StPause : StRun;
         end
         StRun: begin
            // stop takes priority over a step due on the same cycle
            if (stop) begin
               state_d = StPause;
            end else if (presc_q == PRE_MAX) begin
               presc_d = '0;
               if (tick_q == speed_q) begin
                  tick_d  = '0;
                  advance = 1'b1;
               end else begin
                  tick_d = tick_q + SPEED_W'(1);
               end
            end else begin
               presc_d = presc_q + PRE_W'(1);
            end
         end
         StPause: begin
            if (!stop) state_d = StRun;
         end
         default: state_d = StIdle;
      endcase

      if (advance) begin
         step_d  = 1'b1;
         speed_d = speed;
         if (!mode) begin
            dir_d = 1'b0;
            if (pos_q == LAST_POS) begin
               pos_d  = '0;
               laps_d = laps_q + 8'd1;
            end else begin
               pos_d = pos_q + POS_W'(1);
            end
         end else if (!dir_q) begin
            // arriving from wrap mode at the top end bounces straight back down
            if (pos_q == LAST_POS) begin
               pos_d = LAST_POS - POS_W'(1);
               dir_d = 1'b1;
            end else begin
               pos_d = pos_q + POS_W'(1);
               dir_d = (pos_q == LAST_POS - POS_W'(1));
            end
         end else begin
            if (pos_q == '0) begin
               pos_d = POS_W'(1);
               dir_d = 1'b0;
            end else begin
               pos_d = pos_q - POS_W'(1);
               if (pos_q == POS_W'(1)) begin
                  dir_d  = 1'b0;
                  laps_d = laps_q + 8'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         presc_q <= '0;
         tick_q  <= '0;
         speed_q <= '0;
         pos_q   <= '0;
         dir_q   <= 1'b0;
         laps_q  <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         speed_q <= speed_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         laps_q  <= laps_d;
         step_q  <= step_d;
      end
   end

`ifdef CHASE_TRAIL_EN
   logic [POS_W-1:0] trail1_q, trail2_q;
   logic [1:0]       trail_vld_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         trail1_q    <= '0;
         trail2_q    <= '0;
         trail_vld_q <= '0;
      end else if (advance) begin
         trail1_q    <= pos_q;
         trail2_q    <= trail1_q;
         trail_vld_q <= {trail_vld_q[0], 1'b1};
      end
   end

   always_comb begin
      led         = '0;
      led[pos_q]  = 1'b1;
      if (trail_vld_q[0]) led[trail1_q] = 1'b1;
      if (trail_vld_q[1]) led[trail2_q] = 1'b1;
   end
`else
   always_comb begin
      led        = '0;
      led[pos_q] = 1'b1;
   end
`endif

   assign pos  = pos_q;
   assign dir  = dir_q;
   assign step = step_q;
   assign laps = laps_q;

endmodule

// File: tb/tb_chase_sequencer.sv
// Self-checking bench for chase_sequencer: vector table, directed multi-cycle sequences and
// randomized stimulus against a cycle-count reference model. Honours CHASE_TRAIL_EN.
module tb_chase_sequencer;

   localparam int D  = 4;
   localparam int N  = 16;
   localparam int SW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          stop = 1'b0;
   logic          mode = 1'b0;
   logic [SW-1:0] speed = '0;
   logic [N-1:0]  led;
   logic [3:0]    pos;
   logic          dir, step;
   logic [7:0]    laps;

   int n_pass  = 0;
   int n_total = 0;

   chase_sequencer #(.CLK_DIV_BASE(D), .N_LEDS(N), .SPEED_W(SW)) dut (
      .clk(clk), .reset(reset), .stop(stop), .speed(speed), .mode(mode),
      .led(led), .pos(pos), .dir(dir), .step(step), .laps(laps)
   );

   always #5 clk = ~clk;

   // Reference model: counts active RUN cycles against the period, walks a lap phase index.
   int m_phase = 0, m_cnt = 0, m_spd = 0, m_pos = 0, m_laps = 0, m_t1 = -1, m_t2 = -1;
   bit m_dir = 1'b0, m_step = 1'b0;

   always @(posedge clk) begin : mdl
      int ph, cnt, spd, p, lp, t1, t2, k;
      bit d, st;
      ph = m_phase; cnt = m_cnt; spd = m_spd; p = m_pos; lp = m_laps;
      t1 = m_t1; t2 = m_t2; d = m_dir; st = 1'b0;
      if (reset) begin
         ph = 0; cnt = 0; spd = 0; p = 0; d = 0; lp = 0; t1 = -1; t2 = -1;
      end else begin
         case (ph)
            0: begin
               spd = int'(speed);
               ph  = stop ? 2 : 1;
            end
            1: begin
               if (stop) ph = 2;
               else begin
                  cnt++;
                  if (cnt == (spd + 1) * D) begin
                     cnt = 0; spd = int'(speed); st = 1'b1;
                     t2 = t1; t1 = p;
                     if (!mode) begin
                        p = (p + 1) % N; d = 1'b0;
                        if (p == 0) lp = (lp + 1) % 256;
                     end else begin
                        k = d ? 2 * N - 2 - p : p;
                        k = (k + 1) % (2 * N - 2);
                        if (k == 0) lp = (lp + 1) % 256;
                        p = (k <= N - 1) ? k : 2 * N - 2 - k;
                        d = (k >= N - 1);
                     end
                  end
               end
            end
            default: if (!stop) ph = 1;
         endcase
      end
      m_phase <= ph; m_cnt <= cnt; m_spd <= spd; m_pos <= p; m_laps <= lp;
      m_t1 <= t1; m_t2 <= t2; m_dir <= d; m_step <= st;
   end

   function automatic logic [N-1:0] mled(input int p, input int t1, input int t2);
      logic [N-1:0] v;
      v = '0;
      v[p] = 1'b1;
`ifdef CHASE_TRAIL_EN
      if (t1 >= 0) v[t1] = 1'b1;
      if (t2 >= 0) v[t2] = 1'b1;
`endif
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_step(input int budget, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!step && n < budget);
      if (!step) begin
         n_total++;
         $display("FAIL step_timeout: no step within %0d cycles", budget);
      end
   endtask

   typedef struct {
      bit          rst;
      bit          stp;
      bit          e_step;
      int          e_pos;
      logic [15:0] e_led;
      logic [15:0] e_led_tr;
   } vec_t;

   vec_t tv[19];

   initial begin
      int n, p0, bad;
      logic [15:0] el;

      tv[0]  = '{1, 0, 0, 0, 16'h0001, 16'h0001};
      tv[1]  = '{0, 0, 0, 0, 16'h0001, 16'h0001};
      tv[2]  = '{0, 0, 0, 0, 16'h0001, 16'h0001};
      tv[3]  = '{0, 0, 0, 0, 16'h0001, 16'h0001};
      tv[4]  = '{0, 0, 0, 0, 16'h0001, 16'h0001};
      tv[5]  = '{0, 0, 1, 1, 16'h0002, 16'h0003};
      tv[6]  = '{0, 0, 0, 1, 16'h0002, 16'h0003};
      tv[7]  = '{0, 0, 0, 1, 16'h0002, 16'h0003};
      tv[8]  = '{0, 0, 0, 1, 16'h0002, 16'h0003};
      tv[9]  = '{0, 0, 1, 2, 16'h0004, 16'h0007};
      tv[10] = '{1, 0, 0, 0, 16'h0001, 16'h0001};
      tv[11] = '{0, 0, 0, 0, 16'h0001, 16'h0001};
      tv[12] = '{0, 1, 0, 0, 16'h0001, 16'h0001};
      tv[13] = '{0, 1, 0, 0, 16'h0001, 16'h0001};
      tv[14] = '{0, 0, 0, 0, 16'h0001, 16'h0001};
      tv[15] = '{0, 0, 0, 0, 16'h0001, 16'h0001};
      tv[16] = '{0, 0, 0, 0, 16'h0001, 16'h0001};
      tv[17] = '{0, 0, 0, 0, 16'h0001, 16'h0001};
      tv[18] = '{0, 0, 1, 1, 16'h0002, 16'h0003};

      for (int i = 0; i < 19; i++) begin
         reset = tv[i].rst;
         stop  = tv[i].stp;
`ifdef CHASE_TRAIL_EN
         el = tv[i].e_led_tr;
`else
         el = tv[i].e_led;
`endif
         cyc();
         check($sformatf("vec%0d", i), {step, pos, dir, laps, led},
               {tv[i].e_step, 4'(tv[i].e_pos), 1'b0, 8'd0, el});
      end

      // Slow wrap: 512-cycle period, one lap, then a mid-period speed change.
      reset = 1'b1; speed = 8'h7F; mode = 1'b0; stop = 1'b0;
      cyc();
      reset = 1'b0;
      wait_step(600, n);
      check("slow_first", n, 513);
      for (int i = 0; i < 15; i++) begin
         wait_step(600, n);
         check("slow_period", n, 512);
      end
`ifdef CHASE_TRAIL_EN
      el = 16'hC001;
`else
      el = 16'h0001;
`endif
      check("slow_lap", {pos, laps, led}, {4'd0, 8'd1, el});
      repeat (100) cyc();
      speed = 8'h00;
      wait_step(600, n);
      check("speed_chg_cur", n + 100, 512);
      wait_step(600, n);
      check("speed_chg_next", n, 4);

      // Stop held across a due step; counting resumes from where it froze.
      cyc();
      cyc();
      stop = 1'b1;
      p0 = int'(pos);
      bad = 0;
      repeat (20) begin
         cyc();
         if (step || int'(pos) != p0) bad++;
      end
      check("stop_hold", bad, 0);
      stop = 1'b0;
      wait_step(20, n);
      check("stop_release", n, 3);
      check("stop_pos", pos, 4'((p0 + 1) % N));

      // Ping-pong lap of 30 steps.
      reset = 1'b1; mode = 1'b1; speed = 8'h00;
      cyc();
      reset = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         wait_step(20, n);
         check($sformatf("pp_step%0d", k), {pos, dir, laps},
               {4'((k <= 15) ? k : 30 - k), 1'((k >= 15 && k < 30) ? 1 : 0),
                8'((k == 30) ? 1 : 0)});
      end
      for (int k = 0; k < 81; k++) wait_step(20, n);
      check("pp_mid", {pos, dir, laps}, {4'd9, 1'b1, 8'd3});
      reset = 1'b1;
      cyc();
      check("mid_reset", {led, pos, dir, step, laps}, {16'h0001, 4'd0, 1'b0, 1'b0, 8'd0});
      reset = 1'b0; mode = 1'b0;
      wait_step(20, n);
      check("after_reset_step", {n[7:0], pos}, {8'd5, 4'd1});

      // Lap counter rolls over 255 -> 0.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int k = 0; k < 255 * 16; k++) wait_step(20, n);
      check("laps_255", laps, 8'd255);
      for (int k = 0; k < 16; k++) wait_step(20, n);
      check("laps_wrap", {pos, laps}, {4'd0, 8'd0});

      // Randomized run against the reference model.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         stop = ($urandom_range(7) == 0);
         if ($urandom_range(15) == 0) mode = ~mode;
         if ($urandom_range(31) == 0) speed = SW'($urandom_range(3));
         reset = ($urandom_range(499) == 0);
         cyc();
         check("model", {led, pos, dir, step, laps},
               {mled(m_pos, m_t1, m_t2), 4'(m_pos), m_dir, m_step, 8'(m_laps)});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
